// File: rtl/cntr_pkg.sv
// Shared types and defaults for the up/down modulo counter and the
// prescaler it uses.
package cntr_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // End-of-range behaviour
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Default geometry: a 4-bit counter over the full 0..15 range, stepping every cycle
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_MODULO   = 16;
    localparam int DEF_PRESCALE = 1;

    // Prescaler register width; a divide-by-1 still keeps a one-bit register
    function automatic int prescale_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/cntr_prescaler.sv
// Clock-enable prescaler: produces one tick per PRESCALE enabled cycles.
// The phase counter only advances while en is high, so dropping en
// preserves the progress toward the next tick.
module cntr_prescaler
    import cntr_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    // Phase counter 0..PRESCALE-1; it wraps on the tick cycle. PRESCALE=1
    // parks it at 0, so the tick is permanently asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (sync_clr) begin
            phase <= '0;
        end else if (en) begin
            if (phase == LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

    // The tick is decoded from the current phase; the counter qualifies it with en
    assign tick = (phase == LAST);

endmodule

// File: rtl/updown_mod_cntr.sv
// Parametrised up/down modulo counter with synchronous clear and load,
// wrap or saturate at the range ends, a prescaled clock enable, a
// combinational terminal count and a registered wrap pulse.
module updown_mod_cntr
    import cntr_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODULO   = DEF_MODULO,
    parameter int SATURATE = MODE_WRAP,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Reject illegal geometries when the design is elaborated
    if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
        $error("updown_mod_cntr: MODULO=%0d is outside 2..2**WIDTH (WIDTH=%0d)", MODULO, WIDTH);
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_mod_cntr: PRESCALE=%0d must be at least 1", PRESCALE);
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
        $error("updown_mod_cntr: SATURATE=%0d must be 0 or 1", SATURATE);
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam bit SAT_EN = (SATURATE == MODE_SAT);

    dir_e             dir;
    logic             tick;
    logic             step;
    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    assign dir    = dir_e'(up_dn);
    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);
    assign step   = en && tick;

    // Out-of-range load values would land in the unreachable region, so pin them to the top
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Clear and load both restart the prescale period
    cntr_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (clr || load),
        .tick     (tick)
    );

    // Next count and wrap pulse, in clr > load > step priority
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (clr) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = load_clamped;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (!at_max) begin
                    count_nxt = count + WIDTH'(1);
                end else if (!SAT_EN) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    count_nxt = count - WIDTH'(1);
                end else if (!SAT_EN) begin
                    count_nxt = MAX_VAL;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    // Count and wrap registers; wrap lines up with the wrapped count value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Terminal count follows the live direction, independent of en and the prescaler
    assign tc = ((dir == DIR_UP) && at_max) || ((dir == DIR_DOWN) && at_min);

endmodule

// File: tb/tb_updown_mod_cntr.sv
module tb_updown_mod_cntr;

    localparam int NI = 4;
    localparam int MODS [NI] = '{16, 10, 10, 10};
    localparam int SATS [NI] = '{0, 0, 1, 0};
    localparam int PRES [NI] = '{1, 1, 1, 3};

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] dcnt  [NI];
    logic       dtc   [NI];
    logic       dwrap [NI];

    int n_cmp;
    int n_err;

    // Reference model state: count value, enabled cycles since the last step, wrap pulse
    int mc [NI];
    int mp [NI];
    bit mw [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        updown_mod_cntr #(
            .WIDTH    (4),
            .MODULO   (MODS[g]),
            .SATURATE (SATS[g]),
            .PRESCALE (PRES[g])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .up_dn    (up_dn),
            .clr      (clr),
            .load     (load),
            .load_val (load_val),
            .count    (dcnt[g]),
            .tc       (dtc[g]),
            .wrap     (dwrap[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit exp_tc(input int i);
        return up_dn ? (mc[i] == MODS[i] - 1) : (mc[i] == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mc[i] = 0;
            mp[i] = 0;
            mw[i] = 1'b0;
        end
    endtask

    // One rising edge applied to the behavioural model using the inputs currently driven
    task automatic model_edge();
        int lv;
        lv = int'(load_val);
        for (int i = 0; i < NI; i++) begin
            mw[i] = 1'b0;
            if (clr) begin
                mc[i] = 0;
                mp[i] = 0;
            end else if (load) begin
                mc[i] = (lv > MODS[i] - 1) ? MODS[i] - 1 : lv;
                mp[i] = 0;
            end else if (en) begin
                mp[i] = mp[i] + 1;
                if (mp[i] == PRES[i]) begin
                    mp[i] = 0;
                    if (up_dn) begin
                        if (mc[i] + 1 < MODS[i]) mc[i] = mc[i] + 1;
                        else if (SATS[i] == 0) begin mc[i] = 0; mw[i] = 1'b1; end
                    end else begin
                        if (mc[i] > 0) mc[i] = mc[i] - 1;
                        else if (SATS[i] == 0) begin mc[i] = MODS[i] - 1; mw[i] = 1'b1; end
                    end
                end
            end
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        #101;
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (dcnt[i] !== 4'd0) begin n_err++; $display("FAIL reset_count inst%0d got %0d want 0", i, dcnt[i]); end
            n_cmp++;
            if (dwrap[i] !== 1'b0) begin n_err++; $display("FAIL reset_wrap inst%0d got %0b want 0", i, dwrap[i]); end
            n_cmp++;
            if (dtc[i] !== 1'b1) begin n_err++; $display("FAIL reset_tc inst%0d got %0b want 1", i, dtc[i]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_down_wrap();
        int e0;
        en = 1'b1; up_dn = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick_clk();
            e0 = (16 - (k % 16)) % 16;
            n_cmp++;
            if (dcnt[0] !== 4'(e0)) begin n_err++; $display("FAIL down_seq step%0d got %0d want %0d", k, dcnt[0], e0); end
            n_cmp++;
            if (dwrap[0] !== (e0 == 15)) begin n_err++; $display("FAIL down_wrap step%0d got %0b want %0b", k, dwrap[0], e0 == 15); end
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (dcnt[i] !== 4'(mc[i])) begin n_err++; $display("FAIL down_model_count inst%0d got %0d want %0d", i, dcnt[i], mc[i]); end
                n_cmp++;
                if (dtc[i] !== exp_tc(i)) begin n_err++; $display("FAIL down_model_tc inst%0d got %0b want %0b", i, dtc[i], exp_tc(i)); end
            end
        end
    endtask

    task automatic test_modulo_up();
        clr = 1'b1;
        tick_clk();
        clr = 1'b0; up_dn = 1'b1; en = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick_clk();
            n_cmp++;
            if (dcnt[1] !== 4'(k % 10)) begin n_err++; $display("FAIL mod10_seq step%0d got %0d want %0d", k, dcnt[1], k % 10); end
            n_cmp++;
            if (dtc[1] !== (k % 10 == 9)) begin n_err++; $display("FAIL mod10_tc step%0d got %0b want %0b", k, dtc[1], k % 10 == 9); end
            n_cmp++;
            if (dwrap[1] !== (k % 10 == 0)) begin n_err++; $display("FAIL mod10_wrap step%0d got %0b want %0b", k, dwrap[1], k % 10 == 0); end
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (dcnt[i] !== 4'(mc[i]) || dwrap[i] !== mw[i]) begin
                    n_err++; $display("FAIL up_model inst%0d got %0d/%0b want %0d/%0b", i, dcnt[i], dwrap[i], mc[i], mw[i]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int sat_up [4] = '{8, 9, 9, 9};
        load = 1'b1; load_val = 4'd7;
        tick_clk();
        load = 1'b0; up_dn = 1'b1; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick_clk();
            n_cmp++;
            if (dcnt[2] !== 4'(sat_up[k])) begin n_err++; $display("FAIL sat_up step%0d got %0d want %0d", k, dcnt[2], sat_up[k]); end
            n_cmp++;
            if (dwrap[2] !== 1'b0) begin n_err++; $display("FAIL sat_up_wrap step%0d got %0b want 0", k, dwrap[2]); end
        end
        up_dn = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick_clk();
            n_cmp++;
            if (dcnt[2] !== 4'((9 - k) < 0 ? 0 : 9 - k)) begin n_err++; $display("FAIL sat_down step%0d got %0d want %0d", k, dcnt[2], (9 - k) < 0 ? 0 : 9 - k); end
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (dcnt[i] !== 4'(mc[i]) || dwrap[i] !== mw[i] || dtc[i] !== exp_tc(i)) begin
                    n_err++; $display("FAIL sat_model inst%0d got %0d/%0b/%0b want %0d/%0b/%0b", i, dcnt[i], dwrap[i], dtc[i], mc[i], mw[i], exp_tc(i));
                end
            end
        end
    endtask

    task automatic test_prescale_freeze();
        int held;
        clr = 1'b1;
        tick_clk();
        clr = 1'b0; up_dn = 1'b1; en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick_clk();
            n_cmp++;
            if (dcnt[3] !== 4'(k / 3)) begin n_err++; $display("FAIL pre_run step%0d got %0d want %0d", k, dcnt[3], k / 3); end
        end
        en = 1'b0;
        held = int'(dcnt[3]);
        for (int k = 0; k < 5; k++) begin
            tick_clk();
            n_cmp++;
            if (dcnt[3] !== 4'd2) begin n_err++; $display("FAIL pre_frozen cycle%0d got %0d want 2", k, dcnt[3]); end
        end
        en = 1'b1;
        // Seven enabled cycles already happened, so two more reach the ninth and the next step
        for (int k = 8; k <= 13; k++) begin
            tick_clk();
            n_cmp++;
            if (dcnt[3] !== 4'(k / 3)) begin n_err++; $display("FAIL pre_resume step%0d got %0d want %0d (held %0d)", k, dcnt[3], k / 3, held); end
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (dcnt[i] !== 4'(mc[i]) || dwrap[i] !== mw[i]) begin
                    n_err++; $display("FAIL pre_model inst%0d got %0d/%0b want %0d/%0b", i, dcnt[i], dwrap[i], mc[i], mw[i]);
                end
            end
        end
    endtask

    task automatic test_load_clr();
        en = 1'b0; load = 1'b1; load_val = 4'd12;
        tick_clk();
        n_cmp++;
        if (dcnt[1] !== 4'd9) begin n_err++; $display("FAIL load_clamp got %0d want 9", dcnt[1]); end
        n_cmp++;
        if (dcnt[0] !== 4'd12) begin n_err++; $display("FAIL load_full got %0d want 12", dcnt[0]); end
        clr = 1'b1;
        tick_clk();
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (dcnt[i] !== 4'd0) begin n_err++; $display("FAIL clr_over_load inst%0d got %0d want 0", i, dcnt[i]); end
        end
        clr = 1'b0; en = 1'b1; up_dn = 1'b1; load_val = 4'd5;
        tick_clk();
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (dcnt[i] !== 4'd5 || dwrap[i] !== 1'b0) begin n_err++; $display("FAIL load_over_step inst%0d got %0d/%0b want 5/0", i, dcnt[i], dwrap[i]); end
        end
        load = 1'b0;
    endtask

    task automatic test_async_reset();
        clr = 1'b1;
        tick_clk();
        clr = 1'b0; up_dn = 1'b1; en = 1'b1;
        repeat (6) tick_clk();
        n_cmp++;
        if (dcnt[0] !== 4'd6) begin n_err++; $display("FAIL arst_pre got %0d want 6", dcnt[0]); end
        #3;
        rst_n = 1'b0;
        model_reset();
        #2;
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (dcnt[i] !== 4'd0 || dwrap[i] !== 1'b0) begin n_err++; $display("FAIL arst_mid inst%0d got %0d/%0b want 0/0", i, dcnt[i], dwrap[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick_clk();
            n_cmp++;
            if (dcnt[1] !== 4'(k)) begin n_err++; $display("FAIL arst_resume step%0d got %0d want %0d", k, dcnt[1], k); end
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (dcnt[i] !== 4'(mc[i])) begin n_err++; $display("FAIL arst_model inst%0d got %0d want %0d", i, dcnt[i], mc[i]); end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 7) != 0);
            up_dn    = ($urandom_range(0, 15) < 9);
            clr      = ($urandom_range(0, 40) == 0);
            load     = ($urandom_range(0, 25) == 0);
            load_val = 4'($urandom_range(0, 15));
            tick_clk();
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (dcnt[i] !== 4'(mc[i])) begin n_err++; $display("FAIL rand_count cyc%0d inst%0d got %0d want %0d", k, i, dcnt[i], mc[i]); end
                n_cmp++;
                if (dwrap[i] !== mw[i]) begin n_err++; $display("FAIL rand_wrap cyc%0d inst%0d got %0b want %0b", k, i, dwrap[i], mw[i]); end
                n_cmp++;
                if (dtc[i] !== exp_tc(i)) begin n_err++; $display("FAIL rand_tc cyc%0d inst%0d got %0b want %0b", k, i, dtc[i], exp_tc(i)); end
            end
        end
        en = 1'b0; clr = 1'b0; load = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_down_wrap();
        test_modulo_up();
        test_saturate();
        test_prescale_freeze();
        test_load_clr();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
